// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, constants and arbitration function for bus_arbiter
package bus_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic M_CPU = 1'b0;
  localparam logic M_EXT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // Round-robin choice: a lone requester wins; on a tie the master that was
  // not granted last wins; no requester returns to IDLE.
  function automatic arb_state_t pick(input logic r0, input logic r1, input logic last_gnt);
    arb_state_t nxt;
    nxt = IDLE;
    if (r0 && r1) begin
      nxt = (last_gnt == M_CPU) ? GNT1 : GNT0;
    end else if (r0) begin
      nxt = GNT0;
    end else if (r1) begin
      nxt = GNT1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/grant bundle plus the shared slave access port
interface bus_arbiter_if;
  import bus_arb_pkg::*;

  logic              m0_req;
  logic              m0_lock;
  logic              m0_wr;
  logic [STRB_W-1:0] m0_bytes;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_error;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_wr;
  logic [STRB_W-1:0] m1_bytes;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_error;

  logic              s_en;
  logic              s_wr;
  logic [STRB_W-1:0] s_bytes;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_error;

  // Master side: the two masters and the downstream bus that answers them.
  modport master (
    output m0_req, m0_lock, m0_wr, m0_bytes, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_error,
    output m1_req, m1_lock, m1_wr, m1_bytes, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_error,
    input  s_en, s_wr, s_bytes, s_addr, s_wdata,
    output s_rdata, s_error
  );

  // Slave side: the arbiter itself.
  modport slave (
    input  m0_req, m0_lock, m0_wr, m0_bytes, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_error,
    input  m1_req, m1_lock, m1_wr, m1_bytes, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata, m1_error,
    output s_en, s_wr, s_bytes, s_addr, s_wdata,
    input  s_rdata, s_error
  );

endinterface

// File: rtl/arb_hold_cnt.sv
// rtl/arb_hold_cnt.sv - 8-bit saturating locked-beat counter with MAX_HOLD limit compare
module arb_hold_cnt #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q;

  // Count locked beats of the current grant; saturate rather than wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 8'd0;
    end else if (clr) begin
      cnt_q <= 8'd0;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign at_max = (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter with locked bursts; ARB_LOCK_TIMEOUT_EN enables forced lock release
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.slave  bus_if,
  output logic          arb_timeout
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be within 2..255");
  end

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       beat0, beat1;
  logic       force_rel;

  // Grants are decoded straight from the state register, so they are glitch-free.
  assign bus_if.m0_gnt = (state_q == GNT0);
  assign bus_if.m1_gnt = (state_q == GNT1);

  assign beat0 = bus_if.m0_gnt && bus_if.m0_req;
  assign beat1 = bus_if.m1_gnt && bus_if.m1_req;

`ifdef ARB_LOCK_TIMEOUT_EN
  logic hold_inc;
  logic hold_at_max;
  logic timeout_q;

  // A lock is overridden only when it is actually being asserted on a beat,
  // the limit is reached and the other master is waiting.
  assign force_rel = hold_at_max &&
                     ((beat0 && bus_if.m0_lock && bus_if.m1_req) ||
                      (beat1 && bus_if.m1_lock && bus_if.m0_req));
  assign hold_inc  = ((beat0 && bus_if.m0_lock) || (beat1 && bus_if.m1_lock)) && !force_rel;

  arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (hold_inc),
    .clr    (!hold_inc),
    .at_max (hold_at_max)
  );

  // Timeout pulse lands in the first cycle of the new grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign force_rel   = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // State and round-robin history registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= M_EXT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next grant: hold while a locked beat runs, otherwise re-arbitrate.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = pick(bus_if.m0_req, bus_if.m1_req, last_q);
      GNT0: begin
        if (beat0 && bus_if.m0_lock && !force_rel) begin
          state_d = GNT0;
        end else begin
          state_d = pick(bus_if.m0_req, bus_if.m1_req, last_q);
        end
      end
      GNT1: begin
        if (beat1 && bus_if.m1_lock && !force_rel) begin
          state_d = GNT1;
        end else begin
          state_d = pick(bus_if.m0_req, bus_if.m1_req, last_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Remember whoever receives the next grant.
  always_comb begin
    last_d = last_q;
    if (state_d == GNT0) begin
      last_d = M_CPU;
    end else if (state_d == GNT1) begin
      last_d = M_EXT;
    end
  end

  // Slave port carries the beating master's fields, zero otherwise.
  always_comb begin
    bus_if.s_en    = 1'b0;
    bus_if.s_wr    = 1'b0;
    bus_if.s_bytes = '0;
    bus_if.s_addr  = '0;
    bus_if.s_wdata = '0;
    if (beat0) begin
      bus_if.s_en    = 1'b1;
      bus_if.s_wr    = bus_if.m0_wr;
      bus_if.s_bytes = bus_if.m0_bytes;
      bus_if.s_addr  = bus_if.m0_addr;
      bus_if.s_wdata = bus_if.m0_wdata;
    end else if (beat1) begin
      bus_if.s_en    = 1'b1;
      bus_if.s_wr    = bus_if.m1_wr;
      bus_if.s_bytes = bus_if.m1_bytes;
      bus_if.s_addr  = bus_if.m1_addr;
      bus_if.s_wdata = bus_if.m1_wdata;
    end
  end

  assign bus_if.m0_rdata = bus_if.m0_gnt ? bus_if.s_rdata : '0;
  assign bus_if.m1_rdata = bus_if.m1_gnt ? bus_if.s_rdata : '0;
  assign bus_if.m0_error = bus_if.m0_gnt && bus_if.s_error;
  assign bus_if.m1_error = bus_if.m1_gnt && bus_if.s_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic arb_timeout;
  int   tests = 0;
  int   fails = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus_if      (bif),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bif.m0_req = 1'b0; bif.m0_lock = 1'b0; bif.m0_wr = 1'b0;
    bif.m0_bytes = '0; bif.m0_addr = '0; bif.m0_wdata = '0;
    bif.m1_req = 1'b0; bif.m1_lock = 1'b0; bif.m1_wr = 1'b0;
    bif.m1_bytes = '0; bif.m1_addr = '0; bif.m1_wdata = '0;
    bif.s_rdata = '0; bif.s_error = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_all();
    nxt();
    nxt();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_g [4];
    logic [63:0] exp_a [4];

    // Reset values and single-requester read.
    do_reset();
    #1;
    chk("rst_m0_gnt", bif.m0_gnt, 0);
    chk("rst_m1_gnt", bif.m1_gnt, 0);
    chk("rst_s_en", bif.s_en, 0);
    chk("rst_timeout", arb_timeout, 0);
    bif.m0_req = 1'b1; bif.m0_addr = 64'h8000_0000; bif.m0_bytes = 8'h08;
    #1;
    chk("lat_no_gnt_yet", bif.m0_gnt, 0);
    chk("idle_s_en", bif.s_en, 0);
    nxt();
    bif.s_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("t1_m0_gnt", bif.m0_gnt, 1);
    chk("t1_m1_gnt", bif.m1_gnt, 0);
    chk("t1_s_en", bif.s_en, 1);
    chk("t1_s_wr", bif.s_wr, 0);
    chk("t1_s_addr", bif.s_addr, 64'h8000_0000);
    chk("t1_s_bytes", bif.s_bytes, 8'h08);
    chk("t1_m0_rdata", bif.m0_rdata, 64'h1122_3344_5566_7788);
    chk("t1_m1_rdata", bif.m1_rdata, 0);
    nxt();
    bif.m0_req = 1'b0;
    #1;
    chk("noreq_gnt_kept", bif.m0_gnt, 1);
    chk("noreq_s_en", bif.s_en, 0);
    chk("noreq_s_addr", bif.s_addr, 0);
    nxt();
    #1;
    chk("release_idle", {bif.m0_gnt, bif.m1_gnt}, 2'b00);

    // Two unlocked requesters alternate 0,1,0,1.
    do_reset();
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_a = '{64'h100, 64'h200, 64'h100, 64'h200};
    bif.m0_req = 1'b1; bif.m0_addr = 64'h100; bif.m0_wr = 1'b1; bif.m0_wdata = 64'hAAAA;
    bif.m1_req = 1'b1; bif.m1_addr = 64'h200; bif.m1_wdata = 64'hBBBB;
    for (int i = 0; i < 4; i++) begin
      nxt();
      #1;
      chk($sformatf("rr_gnt%0d", i), {bif.m0_gnt, bif.m1_gnt}, exp_g[i]);
      chk($sformatf("rr_addr%0d", i), bif.s_addr, exp_a[i]);
      chk($sformatf("rr_en%0d", i), bif.s_en, 1);
    end
    chk("rr_wr_from_m1", bif.s_wr, 0);
    chk("rr_wdata_m1", bif.s_wdata, 64'hBBBB);
    idle_all();

    // m1 locked burst of 4 beats while m0 waits.
    do_reset();
    bif.m1_req = 1'b1; bif.m1_lock = 1'b1; bif.m1_addr = 64'h300;
    for (int i = 1; i <= 4; i++) begin
      nxt();
      if (i == 1) begin
        bif.m0_req = 1'b1; bif.m0_addr = 64'h400;
      end
      if (i == 4) bif.m1_lock = 1'b0;
      #1;
      chk($sformatf("burst_gnt%0d", i), {bif.m0_gnt, bif.m1_gnt}, 2'b01);
      chk($sformatf("burst_addr%0d", i), bif.s_addr, 64'h300);
    end
    nxt();
    bif.m1_req = 1'b0;
    #1;
    chk("burst_handover", {bif.m0_gnt, bif.m1_gnt}, 2'b10);
    chk("burst_m0_addr", bif.s_addr, 64'h400);
    chk("burst_no_timeout", arb_timeout, 0);
    idle_all();

    // m0 locked indefinitely with m1 waiting.
    do_reset();
    bif.m0_req = 1'b1; bif.m0_lock = 1'b1; bif.m0_addr = 64'h500;
    bif.m1_req = 1'b1; bif.m1_addr = 64'h600;
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      nxt();
      #1;
      chk($sformatf("to_m0_beat%0d", i), {bif.m0_gnt, bif.m1_gnt, arb_timeout}, 3'b100);
    end
    nxt();
    #1;
    chk("to_switch", {bif.m0_gnt, bif.m1_gnt}, 2'b01);
    chk("to_pulse", arb_timeout, 1);
    chk("to_m1_addr", bif.s_addr, 64'h600);
    nxt();
    #1;
    chk("to_pulse_end", arb_timeout, 0);
    chk("to_back_m0", bif.m0_gnt, 1);
`else
    for (int i = 1; i <= 100; i++) begin
      nxt();
      #1;
      chk($sformatf("hold%0d", i), {bif.m0_gnt, bif.m1_gnt, arb_timeout}, 3'b100);
    end
`endif
    idle_all();

    // Reset in the middle of a GNT1 burst.
    do_reset();
    bif.m1_req = 1'b1; bif.m1_lock = 1'b1; bif.m1_addr = 64'h700;
    nxt(); nxt(); nxt();
    #1;
    chk("pre_rst_m1_gnt", bif.m1_gnt, 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_m1_gnt", bif.m1_gnt, 0);
    chk("async_rst_s_en", bif.s_en, 0);
    bif.m0_req = 1'b1; bif.m0_addr = 64'h800;
    nxt();
    #1;
    chk("in_rst_no_beat", {bif.s_en, bif.m0_gnt, bif.m1_gnt}, 3'b000);
    rstn = 1'b1;
    nxt();
    #1;
    chk("post_rst_m0_first", {bif.m0_gnt, bif.m1_gnt}, 2'b10);
    chk("post_rst_addr", bif.s_addr, 64'h800);
    idle_all();

    // Slave error routed only to the granted master.
    do_reset();
    bif.m0_req = 1'b1; bif.m1_req = 1'b1;
    nxt();
    #1;
    chk("err_seq0", {bif.m0_gnt, bif.m1_gnt}, 2'b10);
    nxt();
    bif.s_error = 1'b1;
    #1;
    chk("err_seq1", {bif.m0_gnt, bif.m1_gnt}, 2'b01);
    chk("err_m1_error", bif.m1_error, 1);
    chk("err_m0_error", bif.m0_error, 0);
    nxt();
    bif.s_error = 1'b0;
    #1;
    chk("err_seq2", {bif.m0_gnt, bif.m1_gnt}, 2'b10);
    chk("err_cleared", bif.m0_error, 0);
    nxt();
    #1;
    chk("err_seq3", {bif.m0_gnt, bif.m1_gnt}, 2'b01);
    idle_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single CPU-side `acs_*` access port of `bus` between the CPU data port (master 0) and a second bus master such as a DMA or debug unit (master 1). It registers grants, runs round-robin arbitration and supports locked bursts. It muxes the granted master's request onto the slave port and routes the slave's `rdata`/`error` back. It sits between the masters and `bus`; downstream memory, uart and timer are unchanged.

## Interface
- `MAX_HOLD`, 16: maximum consecutive locked beats before forced release (used only with `ARB_LOCK_TIMEOUT_EN`); legal 2..255.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `mN_req`  in  1  master N (N=0,1) requests a beat; held until a beat is accepted.
- `mN_lock`  in  1  master N requests to keep the grant after the current beat.
- `mN_wr`, `mN_bytes[7:0]`, `mN_addr[63:0]`, `mN_wdata[63:0]`  in  access fields, same meaning as `acs_*`.
- `mN_gnt`  out  1  registered grant to master N.
- `mN_rdata`  out  64  read data. Equals `s_rdata` when `mN_gnt`, else 0.
- `mN_error`  out  1  Equals `s_error` when `mN_gnt`, else 0.
- `s_en`, `s_wr`, `s_bytes[7:0]`, `s_addr[63:0]`, `s_wdata[63:0]`  out  slave-side access, to `bus` `acs_*`.
- `s_rdata`  in  64  from `bus`.
- `s_error`  in  1  from `bus`.
- `arb_timeout`  out  1  one-cycle pulse on forced release.

## Operation
- States:
  - IDLE: no grant.
  - GNT0: `m0_gnt`=1.
  - GNT1: `m1_gnt`=1.
  - Grants are one-hot or zero.
- Beat: a cycle with `mN_gnt`=1 and `mN_req`=1.
- During a beat:
  - `s_en`=1.
  - All `s_*` fields are taken from master N.
  - `rdata`/`error` are combinational from the slave in the same cycle.
- Outside a beat: `s_en`=0 and all `s_*` outputs are 0.
- Arbitration (function `pick`), used from IDLE or on release:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to `last_gnt` is granted.
  - Neither requesting: next state is IDLE.
- `last_gnt` updates each time a grant is issued.
- From GNTN:
  - If `mN_req`=1 and `mN_lock`=1, stay in GNTN.
  - Otherwise the next state is `pick` over the current requests. This includes regranting N back-to-back if N is the only requester.
- GNTN with `mN_req`=0: no beat. Release and `pick` the next cycle.
- Lock is sampled only in beat cycles.
- Masters must keep their request fields stable while `req`=1 and `gnt`=0.

## Timing
- Reset values:
  - state IDLE.
  - `last_gnt`=1, so master 0 wins the first tie.
  - `m0_gnt`=`m1_gnt`=0.
  - `arb_timeout`=0.
  - hold count 0.
- Grant latency: `req` at cycle t in IDLE gives `gnt` and the first beat at t+1.
- Throughput:
  - A single requester gets one beat per cycle.
  - Two unlocked requesters alternate every cycle: 0,1,0,1.
- Simultaneous release and new request: the switch happens with no idle cycle.
- Reset asserted mid-burst: all outputs drop asynchronously to their reset values. No beat occurs while `rstn`=0.
- `s_error` in a beat only passes through. The grant is unaffected.

## Configuration
- `ARB_LOCK_TIMEOUT_EN` defined:
  - A hold counter increments on each locked beat in the same grant and clears on any grant change.
  - When the count reaches `MAX_HOLD`-1 in a beat and the other master is requesting, the lock is ignored and the grant switches to the other master.
  - `arb_timeout` pulses for 1 cycle, in the cycle after that beat.
- Not defined:
  - Lock is honoured indefinitely.
  - No counter logic exists.
  - `arb_timeout` is tied to 0.

## Structure
- Package `bus_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GNT0, GNT1).
  - the master index constants `M_CPU`=0 and `M_EXT`=1.
  - the width localparams (ADDR 64, DATA 64, STRB 8).
- One sub-module, `arb_hold_cnt`: the 8-bit saturating hold counter with the `MAX_HOLD` compare. It is instantiated only under `ARB_LOCK_TIMEOUT_EN`.

## Test plan
- Reset release, then `m0_req`=1 (rd, addr 0x8000_0000), `m1_req`=0 -> `m0_gnt`=1 one cycle later. `s_addr`=0x8000_0000 and `m0_rdata`=`s_rdata` in that cycle.
- Both request with lock=0 from IDLE after reset -> grant order 0,1,0,1 over 4 cycles with no idle cycle.
- `m1` locked burst of 4 beats while `m0` requests -> `m0_gnt` rises in the cycle after m1's 4th beat (the beat where `m1_lock`=0). `m0` holds its fields stable throughout.
- `ARB_LOCK_TIMEOUT_EN` with `MAX_HOLD`=4: `m0` locked indefinitely, `m1` requesting -> `m1_gnt` after exactly 4 `m0` beats, and `arb_timeout` pulses once in the same cycle as `m1`'s first beat. Without the macro: `m0` holds the grant for 100 cycles and `arb_timeout` stays 0.
- `rstn` low during a GNT1 burst -> `m1_gnt` and `s_en` are 0 immediately. After release with both masters requesting, master 0 is granted first.
- `s_error`=1 during an `m1` beat -> `m1_error`=1 and `m0_error`=0. The grant sequence is unchanged.
